// File: rtl/kingdom_sacred_constants.sv
// Q32.32 sacred constants, registered lookup port and a shift-add self-check of phi^2.
// Define SACRED_SELF_CHECK_EN to build the self-check FSM; otherwise check_* outputs are tied low.
module kingdom_sacred_constants #(
  parameter int TOL_LSB    = 4,
  parameter int AUTO_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] phi,
  output logic [63:0] phi_sq,
  output logic [63:0] phi_inv,
  output logic [63:0] phi_inv_sq,
  output logic [63:0] pi_q,
  output logic [63:0] e_q,
  output logic [63:0] sqrt5,
  input  logic        rd_en,
  input  logic [2:0]  rd_sel,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  input  logic        check_start,
  output logic        check_busy,
  output logic        check_done,
  output logic        check_pass,
  output logic [63:0] check_result
);

  localparam logic [63:0] PHI        = 64'h0000_0001_9E37_79B9;
  localparam logic [63:0] PHI_SQ     = 64'h0000_0002_9E37_79B9;
  localparam logic [63:0] PHI_INV    = 64'h0000_0000_9E37_79B9;
  localparam logic [63:0] PHI_INV_SQ = 64'h0000_0000_61C8_8647;
  localparam logic [63:0] PI_Q       = 64'h0000_0003_243F_6A89;
  localparam logic [63:0] E_Q        = 64'h0000_0002_B7E1_5163;
  localparam logic [63:0] SQRT5      = 64'h0000_0002_3C6E_F373;
  localparam logic [63:0] THREE      = 64'h0000_0003_0000_0000;

  // Hard-wired so parents can use them with clock and reset left floating.
  assign phi        = PHI;
  assign phi_sq     = PHI_SQ;
  assign phi_inv    = PHI_INV;
  assign phi_inv_sq = PHI_INV_SQ;
  assign pi_q       = PI_Q;
  assign e_q        = E_Q;
  assign sqrt5      = SQRT5;

  function automatic logic [63:0] lut(input logic [2:0] sel);
    case (sel)
      3'd0:    lut = PHI;
      3'd1:    lut = PHI_SQ;
      3'd2:    lut = PHI_INV;
      3'd3:    lut = PHI_INV_SQ;
      3'd4:    lut = PI_Q;
      3'd5:    lut = E_Q;
      3'd6:    lut = SQRT5;
      default: lut = THREE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= lut(rd_sel);
    end
  end

`ifdef SACRED_SELF_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, CMP = 2'd2, DONE = 2'd3} state_t;

  state_t       state, state_nxt;
  logic         start;
  logic         started;
  logic [6:0]   cnt;
  // Only product bits [95:0] matter, so the datapath wraps at 96 bits.
  logic [95:0]  acc;
  logic [95:0]  mcand;
  logic [63:0]  mplier;
  logic [63:0]  product_mid;
  logic [63:0]  diff;
  logic [64:0]  sum65;
  logic         verdict;
  logic         unused_lo;

  assign product_mid = acc[95:32];
  assign diff        = (product_mid >= PHI_SQ) ? (product_mid - PHI_SQ) : (PHI_SQ - product_mid);
  assign sum65       = {1'b0, PHI_SQ} + {1'b0, PHI_INV_SQ};
  assign verdict     = (diff <= 64'(TOL_LSB)) && (sum65 == 65'h0_0000_0003_0000_0000);
  assign unused_lo   = ^acc[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (check_start || ((AUTO_CHECK != 0) && !started)) begin
          start     = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     if (cnt == 7'd0) state_nxt = CMP;
      CMP:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started      <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      check_busy   <= 1'b0;
      check_done   <= 1'b0;
      check_pass   <= 1'b0;
      check_result <= '0;
    end else begin
      started <= 1'b1;
      if (start) begin
        cnt        <= 7'd64;
        acc        <= '0;
        mcand      <= {32'b0, PHI};
        mplier     <= PHI;
        check_busy <= 1'b1;
        check_done <= 1'b0;
        check_pass <= 1'b0;
      end else if (state == MUL && cnt != 7'd0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 7'd1;
      end else if (state == CMP) begin
        check_result <= product_mid;
        check_pass   <= verdict;
        check_done   <= 1'b1;
        check_busy   <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg   = check_start ^ (TOL_LSB > 0) ^ (AUTO_CHECK != 0);
  assign check_busy   = 1'b0;
  assign check_done   = 1'b0;
  assign check_pass   = 1'b0;
  assign check_result = '0;
`endif

endmodule

// File: tb/tb_kingdom_sacred_constants.sv
// Directed bench: constants, lookup vector table, and self-check timing/reset sequences.
module tb_kingdom_sacred_constants;

  localparam logic [63:0] C_PHI        = 64'h0000_0001_9E37_79B9;
  localparam logic [63:0] C_PHI_SQ     = 64'h0000_0002_9E37_79B9;
  localparam logic [63:0] C_PHI_INV    = 64'h0000_0000_9E37_79B9;
  localparam logic [63:0] C_PHI_INV_SQ = 64'h0000_0000_61C8_8647;
  localparam logic [63:0] C_PI         = 64'h0000_0003_243F_6A89;
  localparam logic [63:0] C_E          = 64'h0000_0002_B7E1_5163;
  localparam logic [63:0] C_SQRT5      = 64'h0000_0002_3C6E_F373;
  localparam logic [63:0] C_THREE      = 64'h0000_0003_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_en = 1'b0;
  logic [2:0] rd_sel = 3'd0;
  logic check_start = 1'b0;

  logic [63:0] phi, phi_sq, phi_inv, phi_inv_sq, pi_q, e_q, sqrt5, rd_data, check_result;
  logic rd_valid, check_busy, check_done, check_pass;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kingdom_sacred_constants dut (
    .clk(clk), .rst_n(rst_n), .phi(phi), .phi_sq(phi_sq), .phi_inv(phi_inv),
    .phi_inv_sq(phi_inv_sq), .pi_q(pi_q), .e_q(e_q), .sqrt5(sqrt5),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
    .check_start(check_start), .check_busy(check_busy), .check_done(check_done),
    .check_pass(check_pass), .check_result(check_result)
  );

  // Instance with clock and reset never toggling: constants must still be present.
  logic fl_clk = 1'b0;
  logic fl_rst_n = 1'b0;
  logic [63:0] fl_phi, fl_o1, fl_o2, fl_o3, fl_o4, fl_o5, fl_o6, fl_rd, fl_res;
  logic fl_v, fl_b, fl_d, fl_p;
  kingdom_sacred_constants dut_float (
    .clk(fl_clk), .rst_n(fl_rst_n), .phi(fl_phi), .phi_sq(fl_o1), .phi_inv(fl_o2),
    .phi_inv_sq(fl_o3), .pi_q(fl_o4), .e_q(fl_o5), .sqrt5(fl_o6),
    .rd_en(1'b0), .rd_sel(3'd0), .rd_data(fl_rd), .rd_valid(fl_v),
    .check_start(1'b0), .check_busy(fl_b), .check_done(fl_d),
    .check_pass(fl_p), .check_result(fl_res)
  );

  // Tight tolerance instance and manual-start instance share clock and reset.
  logic [63:0] t2_o0, t2_o1, t2_o2, t2_o3, t2_o4, t2_o5, t2_o6, t2_rd, t2_res;
  logic t2_v, t2_busy, t2_done, t2_pass;
  kingdom_sacred_constants #(.TOL_LSB(2)) dut_tol2 (
    .clk(clk), .rst_n(rst_n), .phi(t2_o0), .phi_sq(t2_o1), .phi_inv(t2_o2),
    .phi_inv_sq(t2_o3), .pi_q(t2_o4), .e_q(t2_o5), .sqrt5(t2_o6),
    .rd_en(1'b0), .rd_sel(3'd0), .rd_data(t2_rd), .rd_valid(t2_v),
    .check_start(1'b0), .check_busy(t2_busy), .check_done(t2_done),
    .check_pass(t2_pass), .check_result(t2_res)
  );

  logic [63:0] m_o0, m_o1, m_o2, m_o3, m_o4, m_o5, m_o6, m_rd, m_res;
  logic m_v, m_busy, m_done, m_pass;
  kingdom_sacred_constants #(.AUTO_CHECK(0)) dut_manual (
    .clk(clk), .rst_n(rst_n), .phi(m_o0), .phi_sq(m_o1), .phi_inv(m_o2),
    .phi_inv_sq(m_o3), .pi_q(m_o4), .e_q(m_o5), .sqrt5(m_o6),
    .rd_en(1'b0), .rd_sel(3'd0), .rd_data(m_rd), .rd_valid(m_v),
    .check_start(1'b0), .check_busy(m_busy), .check_done(m_done),
    .check_pass(m_pass), .check_result(m_res)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  sel;
    logic        valid;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[12];
  logic [127:0] prod_model;
  logic [63:0]  exp_res;
  logic [63:0]  exp_diff;
  logic         exp_pass4, exp_pass2;
  logic [64:0]  sum_chk;

  task automatic check_final(input string tag);
    chk({tag, " done"}, 64'(check_done), 64'd1);
    chk({tag, " busy"}, 64'(check_busy), 64'd0);
    chk({tag, " pass"}, 64'(check_pass), 64'(exp_pass4));
    chk({tag, " result"}, check_result, exp_res);
  endtask

  initial begin
    prod_model = {64'b0, C_PHI} * {64'b0, C_PHI};
    exp_res    = prod_model[95:32];
    exp_diff   = (exp_res >= C_PHI_SQ) ? exp_res - C_PHI_SQ : C_PHI_SQ - exp_res;
    exp_pass4  = (exp_diff <= 64'd4);
    exp_pass2  = (exp_diff <= 64'd2);

    vecs[0]  = '{1'b1, 3'd0, 1'b1, C_PHI};
    vecs[1]  = '{1'b1, 3'd1, 1'b1, C_PHI_SQ};
    vecs[2]  = '{1'b1, 3'd2, 1'b1, C_PHI_INV};
    vecs[3]  = '{1'b1, 3'd3, 1'b1, C_PHI_INV_SQ};
    vecs[4]  = '{1'b1, 3'd4, 1'b1, C_PI};
    vecs[5]  = '{1'b1, 3'd5, 1'b1, C_E};
    vecs[6]  = '{1'b1, 3'd6, 1'b1, C_SQRT5};
    vecs[7]  = '{1'b1, 3'd7, 1'b1, C_THREE};
    vecs[8]  = '{1'b0, 3'd1, 1'b0, C_THREE};
    vecs[9]  = '{1'b1, 3'd4, 1'b1, C_PI};
    vecs[10] = '{1'b0, 3'd2, 1'b0, C_PI};
    vecs[11] = '{1'b1, 3'd0, 1'b1, C_PHI};

    #1;
    chk("float phi", fl_phi, C_PHI);
    chk("float phi low word", {32'b0, fl_phi[31:0]}, 64'h9E37_79B9);

    #20;
    chk("reset rd_data", rd_data, 64'd0);
    chk("reset rd_valid", 64'(rd_valid), 64'd0);
    chk("reset busy", 64'(check_busy), 64'd0);
    chk("reset done", 64'(check_done), 64'd0);
    chk("reset pass", 64'(check_pass), 64'd0);
    chk("reset result", check_result, 64'd0);

    chk("const phi", phi, C_PHI);
    chk("const phi_sq", phi_sq, C_PHI_SQ);
    chk("const phi_inv", phi_inv, C_PHI_INV);
    chk("const phi_inv_sq", phi_inv_sq, C_PHI_INV_SQ);
    chk("const pi_q", pi_q, C_PI);
    chk("const e_q", e_q, C_E);
    chk("const sqrt5", sqrt5, C_SQRT5);
    sum_chk = {1'b0, phi_sq} + {1'b0, phi_inv_sq};
    chk("phi_sq+phi_inv_sq", sum_chk[63:0], C_THREE);

    @(negedge clk);
    rst_n = 1'b1;
`ifdef SACRED_SELF_CHECK_EN
    @(posedge clk);  // auto-start edge
    for (int k = 1; k <= 66; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("auto busy k1", 64'(check_busy), 64'd1);
        chk("auto done k1", 64'(check_done), 64'd0);
      end
      if (k == 65) begin
        chk("auto busy k65", 64'(check_busy), 64'd1);
        chk("auto done k65", 64'(check_done), 64'd0);
      end
    end
    check_final("auto");
    chk("tol2 done", 64'(t2_done), 64'd1);
    chk("tol2 pass", 64'(t2_pass), 64'(exp_pass2));
    chk("tol2 result", t2_res, exp_res);
    chk("manual idle busy", 64'(m_busy), 64'd0);
    chk("manual idle done", 64'(m_done), 64'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_en  = vecs[i].en;
      rd_sel = vecs[i].sel;
      @(posedge clk);
      #1;
      chk($sformatf("lookup valid %0d", i), 64'(rd_valid), 64'(vecs[i].valid));
      chk($sformatf("lookup data %0d", i), rd_data, vecs[i].data);
    end
    @(negedge clk);
    rd_en = 1'b0;

`ifdef SACRED_SELF_CHECK_EN
    // Restart from DONE, with a start pulse during MUL that must be ignored.
    check_start = 1'b1;
    @(posedge clk);
    #1;
    chk("restart done cleared", 64'(check_done), 64'd0);
    chk("restart pass cleared", 64'(check_pass), 64'd0);
    chk("restart busy", 64'(check_busy), 64'd1);
    check_start = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      @(posedge clk);
      #1;
      check_start = (k == 29);
      if (k == 65) chk("restart done k65", 64'(check_done), 64'd0);
    end
    check_final("restart");

    // Reset in the middle of MUL, then auto re-run.
    @(negedge clk);
    check_start = 1'b1;
    @(posedge clk);
    #1;
    check_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(check_busy), 64'd0);
    chk("abort done", 64'(check_done), 64'd0);
    chk("abort pass", 64'(check_pass), 64'd0);
    chk("abort result", check_result, 64'd0);
    chk("abort rd_data", rd_data, 64'd0);
    chk("abort rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 66; k++) begin
      @(posedge clk);
      #1;
      if (k == 65) chk("rerun done k65", 64'(check_done), 64'd0);
    end
    check_final("rerun");
`else
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      check_start = (k == 5);
    end
    check_start = 1'b0;
    #1;
    chk("off busy", 64'(check_busy), 64'd0);
    chk("off done", 64'(check_done), 64'd0);
    chk("off pass", 64'(check_pass), 64'd0);
    chk("off result", check_result, 64'd0);
    chk("off tol2 done", 64'(t2_done), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
